// File: rtl/cpu0_bus_pkg.sv
// Shared definitions for the CPU0 bus memory responder: FSM states,
// read/write encoding and the default storage size.
package cpu0_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEFAULT_DEPTH_BYTES = 128;

endpackage

// File: rtl/byte_ram.sv
// Byte-addressed storage with a big-endian 4-byte write port and a
// combinational big-endian 4-byte read port; never reset.
module byte_ram
  import cpu0_bus_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem[wr_addr + AW'(k)] <= wr_data[31-8*k -: 8];
      end
    end
  end

  // Most significant byte lives at the lowest address.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      rd_data[31-8*k -: 8] = mem[rd_addr + AW'(k)];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU bus memory responder: captures one request, waits WAIT_STATES cycles,
// issues a one-cycle ready (with err for out-of-range) and then holds off until en drops.
module mem_responder
  import cpu0_bus_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [31:0] abus,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  // Evaluated in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} + 33'd3) < 33'(DEPTH_BYTES);
  endfunction

  state_t        state;
  logic [2:0]    wcnt;
  logic          cap_rw;
  logic          cap_ok;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;

  logic          commit;
  logic          load_ok;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // The write lands on the edge that leaves RESP, so a reset during
  // WAIT or RESP drops state to IDLE before any storage change.
  assign commit    = (state == ST_RESP) && (cap_rw == RW_WRITE) && cap_ok;
  assign load_ok   = ld_en && (state == ST_IDLE) && !en && in_range(ld_addr);
  assign ram_we    = commit || load_ok;
  assign ram_waddr = commit ? cap_addr : ld_addr[AW-1:0];
  assign ram_wdata = commit ? cap_wdata : ld_data;

  byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_ram (
    .clock  (clock),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_addr(cap_addr),
    .rd_data(ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && en) begin
      cap_rw    <= rw;
      cap_addr  <= abus[AW-1:0];
      cap_wdata <= wdata;
      cap_ok    <= in_range(abus);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            wcnt  <= WAIT_LOAD;
            state <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (wcnt == 3'd0) state <= ST_RESP;
          else              wcnt  <= wcnt - 3'd1;
        end
        ST_RESP: begin
          ready <= 1'b1;
          err   <= !cap_ok;
          if (!cap_ok)                rdata <= '0;
          else if (cap_rw == RW_READ) rdata <= ram_rdata;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=1 and a WAIT_STATES=0 instance share
// all inputs and are checked against a byte-array model of the storage.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, rw = 1'b0, ld_en = 1'b0;
  logic [31:0] abus = '0, wdata = '0, ld_addr = '0, ld_data = '0;
  logic [31:0] rdata1, rdata0;
  logic        ready1, ready0, err1, err0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m [128];
  logic [31:0] exp_rd = '0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [11];

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_BYTES(128), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .abus(abus), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .err(err1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  mem_responder #(.DEPTH_BYTES(128), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .abus(abus), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic bit m_inr(input logic [31:0] a);
    return ({32'd0, a} + 64'd3) < 64'd128;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {m[i], m[i+1], m[i+2], m[i+3]};
  endfunction

  task automatic m_put(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) m[int'(a) + k] = d[31-8*k -: 8];
  endtask

  // Expected response of one bus access, and its effect on the model.
  task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                            output logic e, output logic [31:0] rd);
    if (!m_inr(a)) begin
      e = 1'b1; rd = '0; exp_rd = '0;
    end else if (r) begin
      e = 1'b0; rd = m_word(a); exp_rd = rd;
    end else begin
      e = 1'b0; rd = exp_rd; m_put(a, wd);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
    if (m_inr(a)) m_put(a, d);
  endtask

  task automatic xact(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                      input int hold, input logic [31:0] alt_wd);
    int lat1, lat0, n1, n0;
    logic [31:0] r1, r0;
    logic e1, e0;
    lat1 = -1; lat0 = -1; n1 = 0; n0 = 0; r1 = '0; r0 = '0; e1 = 1'b0; e0 = 1'b0;
    en = 1'b1; rw = r; abus = a; wdata = wd;
    for (int k = 1; k <= 16 + hold; k++) begin
      tick;
      ld_en = 1'b0;
      if (ready1) begin
        n1++;
        if (lat1 < 0) begin lat1 = k - 1; r1 = rdata1; e1 = err1; end
      end
      if (ready0) begin
        n0++;
        if (lat0 < 0) begin lat0 = k - 1; r0 = rdata0; e0 = err0; end
      end
      if (lat1 >= 0 && lat0 >= 0) begin
        if (hold > 0) wdata = alt_wd;
        if (k - 1 >= lat1 + hold) break;
      end
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (ready1) n1++;
      if (ready0) n0++;
    end
    check({tag, " lat ws1"}, 32'(lat1), 32'd2);
    check({tag, " lat ws0"}, 32'(lat0), 32'd1);
    check({tag, " err ws1"}, {31'd0, e1}, {31'd0, e_err});
    check({tag, " err ws0"}, {31'd0, e0}, {31'd0, e_err});
    check({tag, " rdata ws1"}, r1, e_rd);
    check({tag, " rdata ws0"}, r0, e_rd);
    check({tag, " pulses ws1"}, 32'(n1), 32'd1);
    check({tag, " pulses ws0"}, 32'(n0), 32'd1);
    check({tag, " rdata held"}, rdata1, e_rd);
  endtask

  initial begin
    logic e;
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0,          1'b0, 32'h001F_0018};
    tbl[1]  = '{1'b0, 32'h0000_000C, 32'h1322_1000,  1'b0, 32'h001F_0018};
    tbl[2]  = '{1'b1, 32'h0000_000C, 32'h0,          1'b0, 32'h1322_1000};
    tbl[3]  = '{1'b1, 32'h0000_007C, 32'h0,          1'b0, 32'hA1B2_C3D4};
    tbl[4]  = '{1'b1, 32'h0000_007D, 32'h0,          1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b0, 32'h0000_007E, 32'h5555_5555,  1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b1, 32'h0000_007C, 32'h0,          1'b0, 32'hA1B2_C3D4};
    tbl[7]  = '{1'b1, 32'hFFFF_FFFE, 32'h0,          1'b1, 32'h0000_0000};
    tbl[8]  = '{1'b1, 32'h0000_0002, 32'h0,          1'b0, 32'h0018_0000};
    tbl[9]  = '{1'b0, 32'h0000_0005, 32'hCAFE_F00D,  1'b0, 32'h0018_0000};
    tbl[10] = '{1'b1, 32'h0000_0004, 32'h0,          1'b0, 32'h00CA_FEF0};

    #12;
    check("reset ready ws1", {31'd0, ready1}, 32'd0);
    check("reset ready ws0", {31'd0, ready0}, 32'd0);
    check("reset err ws1",   {31'd0, err1},   32'd0);
    check("reset err ws0",   {31'd0, err0},   32'd0);
    check("reset rdata ws1", rdata1, 32'd0);
    check("reset rdata ws0", rdata0, 32'd0);
    reset = 1'b1;
    tick;

    for (int a = 0; a < 128; a += 4) load(32'(a), 32'h0);
    load(32'h0000_0000, 32'h001F_0018);
    load(32'h0000_007C, 32'hA1B2_C3D4);
    load(32'h0000_007E, 32'hFFFF_FFFF);
    load(32'hFFFF_FFFE, 32'h1234_5678);

    for (int i = 0; i < 11; i++) begin
      model_step(tbl[i].rw, tbl[i].addr, tbl[i].wdata, e, rd);
      xact($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].wdata,
           tbl[i].err, tbl[i].rd, 0, 32'h0);
    end
    check("byte view 0x0C", {24'd0, dut1.u_ram.mem[12]}, 32'h13);

    // En held for ten cycles after ready; wdata changes while held must not land.
    model_step(1'b0, 32'h40, 32'h1111_2222, e, rd);
    xact("held write", 1'b0, 32'h40, 32'h1111_2222, e, rd, 10, 32'hBAD0_BAD0);
    model_step(1'b1, 32'h40, 32'h0, e, rd);
    xact("held readback", 1'b1, 32'h40, 32'h0, 1'b0, 32'h1111_2222, 0, 32'h0);

    // Load and request together in IDLE: the request wins.
    ld_en = 1'b1; ld_addr = 32'h30; ld_data = 32'h7777_7777;
    model_step(1'b1, 32'h30, 32'h0, e, rd);
    xact("collide read", 1'b1, 32'h30, 32'h0, 1'b0, 32'h0, 0, 32'h0);
    model_step(1'b1, 32'h30, 32'h0, e, rd);
    xact("collide no load", 1'b1, 32'h30, 32'h0, 1'b0, 32'h0, 0, 32'h0);

    // Reset while the write is in flight.
    model_step(1'b1, 32'h0, 32'h0, e, rd);
    xact("pre-reset read", 1'b1, 32'h0, 32'h0, 1'b0, 32'h001F_0018, 0, 32'h0);
    en = 1'b1; rw = 1'b0; abus = 32'h20; wdata = 32'hDEAD_BEEF;
    tick;
    reset = 1'b0;
    #1;
    check("midreset ready ws1", {31'd0, ready1}, 32'd0);
    check("midreset ready ws0", {31'd0, ready0}, 32'd0);
    check("midreset rdata ws1", rdata1, 32'd0);
    check("midreset rdata ws0", rdata0, 32'd0);
    en = 1'b0;
    tick;
    tick;
    check("in reset ready ws1", {31'd0, ready1}, 32'd0);
    reset = 1'b1;
    exp_rd = '0;
    tick;
    tick;
    check("post reset ready ws1", {31'd0, ready1}, 32'd0);
    check("post reset err ws1", {31'd0, err1}, 32'd0);
    check("post reset rdata ws1", rdata1, 32'd0);
    model_step(1'b1, 32'h20, 32'h0, e, rd);
    xact("reset no commit", 1'b1, 32'h20, 32'h0, 1'b0, 32'h0, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic r;
      logic [31:0] a, wd;
      if ($urandom_range(0, 4) == 0) begin
        load(32'($urandom_range(0, 130)), $urandom);
      end else begin
        r  = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 127));
        wd = $urandom;
        model_step(r, a, wd, e, rd);
        xact($sformatf("rand%0d", i), r, a, wd, e, rd, 0, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
